// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: one-second prescaler, HH:MM:SS time register and
// RUN/PAUSE/SET_HR/SET_MIN mode FSM for the Basys3 digital clock.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   btn_mode/run/inc    one-cycle debounced button pulses
//   sec_tick            one-cycle pulse when time advances
//   hours/minutes/secs  binary time fields
//   mode                RUN=0 PAUSE=1 SET_HR=2 SET_MIN=3
//   blink               blink enable for the field being set
//   pm                  PM flag (12 h build only, else 0)
//
// Build option: define CLKCTL_12H_EN for 12-hour mode (hours 1..12 + pm).

module clock_time_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned TICK_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_run,
  input  logic       btn_inc,
  output logic       sec_tick,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       pm
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PAUSE   = 2'd1,
    SET_HR  = 2'd2,
    SET_MIN = 2'd3
  } mode_t;

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] HALF = TICK_W'(TICK_DIV / 2);
  localparam logic [TICK_W-1:0] ONE  = TICK_W'(1);

`ifdef CLKCTL_12H_EN
  localparam logic [4:0] H_RST = 5'd12;
`else
  localparam logic [4:0] H_RST = 5'd0;
`endif

  mode_t             st;
  mode_t             st_n;
  logic [TICK_W-1:0] presc;
  logic [TICK_W-1:0] presc_n;
  logic [4:0]        hr_n;
  logic [5:0]        mn_n;
  logic [5:0]        sc_n;
  logic              pm_q;
  logic              pm_n;
  logic              adv;
  logic              bl_n;
  logic [4:0]        hr_inc;
  logic              pm_inc;
  logic              ev_mode;
  logic              ev_run;
  logic              ev_inc;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // One hour step, shared by time carry and SET_HR increment.
`ifdef CLKCTL_12H_EN
  assign hr_inc = (hours == 5'd12) ? 5'd1 : hours + 5'd1;
  assign pm_inc = (hours == 5'd11) ? ~pm_q : pm_q;
  assign pm     = pm_q;
`else
  assign hr_inc = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
  assign pm_inc = pm_q;
  assign pm     = 1'b0;
`endif

  // Priority mode > run > inc, made one-hot.
  assign ev_mode = btn_mode;
  assign ev_run  = btn_run & ~btn_mode;
  assign ev_inc  = btn_inc & ~btn_mode & ~btn_run;

  always_comb begin
    st_n    = st;
    presc_n = presc;
    hr_n    = hours;
    mn_n    = minutes;
    sc_n    = seconds;
    pm_n    = pm_q;
    adv     = 1'b0;
    bl_n    = 1'b0;

    unique case (st)
      RUN: begin
        adv     = (presc == LAST);
        presc_n = adv ? '0 : presc + ONE;
      end
      PAUSE: begin
        presc_n = presc;
      end
      default: begin
        presc_n = (presc == LAST) ? '0 : presc + ONE;
      end
    endcase

    if (adv) begin
      sc_n = inc60(seconds);
      if (seconds == 6'd59) begin
        mn_n = inc60(minutes);
        if (minutes == 6'd59) begin
          hr_n = hr_inc;
          pm_n = pm_inc;
        end
      end
    end

    unique case (1'b1)
      ev_mode: begin
        unique case (st)
          RUN, PAUSE: st_n = SET_HR;
          SET_HR:     st_n = SET_MIN;
          SET_MIN: begin
            // Re-entering RUN starts a fresh second.
            st_n    = RUN;
            presc_n = '0;
            sc_n    = '0;
          end
        endcase
      end
      ev_run: begin
        if (st == RUN) begin
          st_n = PAUSE;
        end else if (st == PAUSE) begin
          st_n = RUN;
        end
      end
      ev_inc: begin
        if (st == SET_HR) begin
          hr_n = hr_inc;
          pm_n = pm_inc;
        end else if (st == SET_MIN) begin
          mn_n = inc60(minutes);
        end
      end
      default: begin
        st_n = st_n;
      end
    endcase

    if ((st_n == SET_HR) || (st_n == SET_MIN)) begin
      bl_n = (presc_n >= HALF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= RUN;
      presc    <= '0;
      hours    <= H_RST;
      minutes  <= '0;
      seconds  <= '0;
      pm_q     <= 1'b0;
      sec_tick <= 1'b0;
      blink    <= 1'b0;
    end else begin
      st       <= st_n;
      presc    <= presc_n;
      hours    <= hr_n;
      minutes  <= mn_n;
      seconds  <= sc_n;
      pm_q     <= pm_n;
      sec_tick <= adv;
      blink    <= bl_n;
    end
  end

  assign mode = st;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: scoreboard bench for clock_time_ctrl.
// Reference model keeps time as seconds-of-day and derives fields.

module tb_clock_time_ctrl;

  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_tick;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;
  logic       pm;

  clock_time_ctrl #(
    .TICK_DIV(TD),
    .TICK_W  (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_run (btn_run),
    .btn_inc (btn_inc),
    .sec_tick(sec_tick),
    .hours   (hours),
    .minutes (minutes),
    .seconds (seconds),
    .mode    (mode),
    .blink   (blink),
    .pm      (pm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tick;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] md;
    logic       bl;
    logic       pm;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_now;

  int m_mode;
  int m_cnt;
  int m_t;
  bit m_tick;

  function automatic obs_t expect_now();
    obs_t o;
    int   h24;
    h24    = m_t / 3600;
    o.tick = m_tick;
`ifdef CLKCTL_12H_EN
    o.h  = (h24 % 12 == 0) ? 5'd12 : 5'(h24 % 12);
    o.pm = (h24 >= 12);
`else
    o.h  = 5'(h24);
    o.pm = 1'b0;
`endif
    o.m  = 6'((m_t / 60) % 60);
    o.s  = 6'(m_t % 60);
    o.md = 2'(m_mode);
    o.bl = (m_mode >= 2) && (m_cnt >= TD / 2);
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_t    = 0;
    m_tick = 0;
  endtask

  task automatic model_step(input bit bm, input bit br, input bit bi);
    int h;
    int mi;
    m_tick = 0;
    if (m_mode == 0 && m_cnt == TD - 1) begin
      m_tick = 1;
      m_t    = (m_t + 1) % 86400;
    end
    if (m_mode != 1) m_cnt = (m_cnt + 1) % TD;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    if (bm) begin
      case (m_mode)
        0, 1: m_mode = 2;
        2: m_mode = 3;
        default: begin
          m_mode = 0;
          m_cnt  = 0;
          m_t    = m_t - (m_t % 60);
        end
      endcase
    end else if (br) begin
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) m_mode = 0;
    end else if (bi) begin
      if (m_mode == 2) m_t = m_t + (((h + 1) % 24) - h) * 3600;
      else if (m_mode == 3) m_t = m_t + (((mi + 1) % 60) - mi) * 60;
    end
  endtask

  task automatic drive(input bit bm, input bit br, input bit bi);
    btn_mode = bm;
    btn_run  = br;
    btn_inc  = bi;
    model_step(bm, br, bi);
    exp_q.push_back(expect_now());
  endtask

  task automatic cycle(input bit bm, input bit br, input bit bi);
    @(negedge clk);
    drive(bm, br, bi);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    btn_mode = 0;
    btn_run  = 0;
    btn_inc  = 0;
    #2 rst_n = 1'b0;
    model_reset();
    exp_q.push_back(expect_now());
    ->chk_now;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0);
  endtask

  task automatic set_time(input int h, input int mi);
    cycle(1, 0, 0);
    repeat ((h - m_t / 3600 + 24) % 24) cycle(0, 0, 1);
    cycle(1, 0, 0);
    repeat ((mi - (m_t / 60) % 60 + 60) % 60) cycle(0, 0, 1);
    cycle(1, 0, 0);
  endtask

  always begin : monitor
    obs_t e;
    obs_t a;
    @(posedge clk or chk_now);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {sec_tick, hours, minutes, seconds, mode, blink, pm};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got tick=%0d %0d:%0d:%0d mode=%0d blink=%0d pm=%0d, want tick=%0d %0d:%0d:%0d mode=%0d blink=%0d pm=%0d",
                 $time, a.tick, a.h, a.m, a.s, a.md, a.bl, a.pm,
                 e.tick, e.h, e.m, e.s, e.md, e.bl, e.pm);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    exp_q.push_back(expect_now());
    ->chk_now;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0);
    idle(35);

    for (int i = 0; i < 3 * TD && !(m_mode == 0 && m_cnt == 4); i++)
      cycle(0, 0, 0);
    cycle(0, 1, 0);
    idle(50);
    cycle(0, 1, 0);
    idle(2 * TD);

    set_time(23, 59);
    idle(61 * TD);
    set_time(11, 59);
    idle(61 * TD);
    set_time(12, 59);
    idle(61 * TD);

    cycle(1, 0, 1);
    idle(3);
    cycle(1, 0, 0);
    idle(3);
    async_reset();

    cycle(1, 0, 0);
    repeat (25) cycle(0, 0, 1);
    cycle(1, 0, 0);
    repeat (61) cycle(0, 0, 1);
    cycle(1, 0, 0);
    idle(15);

    for (int i = 0; i < 2 * TD && !m_tick; i++) cycle(0, 0, 0);
    async_reset();

    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 30);
    end
    idle(2);

    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Timekeeping controller for the Basys3 digital clock. It owns a programmable one-second prescaler and an HH:MM:SS time register. A four-state mode FSM sequences the prescaler and the time register through run, pause and set. Debounced single-cycle button pulses come in, and binary time fields plus a per-second tick go out to the display path.

## Interface

Parameters:
- TICK_DIV, 100000000: clk cycles per second tick; legal range 2..2^TICK_W-1.
- TICK_W, 32: prescaler counter width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_mode  in  1  one-cycle pulse; advances the mode FSM.
- btn_run  in  1  one-cycle pulse; toggles RUN/PAUSE.
- btn_inc  in  1  one-cycle pulse; increments the field being set.
- sec_tick  out  1  one-cycle pulse when time advances by one second.
- hours  out  5  hour field, binary.
- minutes  out  6  minute field, 0..59.
- seconds  out  6  second field, 0..59.
- mode  out  2  FSM state: RUN=0, PAUSE=1, SET_HR=2, SET_MIN=3.
- blink  out  1  display blink enable for the field being set.
- pm  out  1  PM flag; constant 0 unless CLKCTL_12H_EN is defined.

## Operation

- Reset values:
  - mode = RUN, prescaler = 0.
  - hours, minutes, seconds = 0; in 12 h mode, hours = 12.
  - sec_tick = 0, blink = 0, pm = 0.
- FSM transitions, one per btn_mode pulse:
  - RUN → SET_HR, PAUSE → SET_HR.
  - SET_HR → SET_MIN, SET_MIN → RUN.
- btn_run toggles RUN ↔ PAUSE. It is ignored in SET_HR and SET_MIN.
- Button priority when pulses coincide: btn_mode > btn_run > btn_inc. Lower-priority pulses in the same cycle are dropped.
- Prescaler:
  - RUN: counts 0..TICK_DIV-1 and wraps to 0.
  - PAUSE: holds its value.
  - SET_HR / SET_MIN: free-runs, but never advances time.
- Time advance (RUN only): happens on the edge where prescaler == TICK_DIV-1.
  - seconds +1. At 59, seconds wrap to 0 with a carry to minutes.
  - minutes wrap 59 → 0 with a carry to hours.
  - hours wrap 23 → 0, so 23:59:59 → 00:00:00.
- btn_inc in SET_HR: hours +1, wrap 23 → 0.
- btn_inc in SET_MIN: minutes +1, wrap 59 → 0, with no carry into hours.
- btn_inc in RUN or PAUSE: ignored.
- Leaving SET_MIN for RUN clears the prescaler and seconds to 0 on that edge.
- blink:
  - SET_HR / SET_MIN: 1 while prescaler ≥ TICK_DIV/2 (integer division), else 0.
  - RUN / PAUSE: 0.
- Arithmetic: prescaler compare is full TICK_W width. Field increments are saturation-free modular arithmetic on the stated ranges; out-of-range values are never produced.

## Timing

- sec_tick is registered. It is high for exactly the cycle after the advancing edge, and the updated time fields are visible in that same cycle.
- In steady RUN, the sec_tick period is exactly TICK_DIV cycles.
- After rst_n is released, the first sec_tick follows the TICK_DIV-th rising edge.
- After SET_MIN → RUN, the next sec_tick follows TICK_DIV further edges.
- Button effects (mode, fields) are visible one cycle after the pulse edge.
- PAUSE → RUN resumes from the held prescaler value. No tick is lost or duplicated.
- rst_n asserted mid-count or mid-set clears all state immediately, independent of clk. A sec_tick in flight is forced to 0.
- No combinational path from inputs to outputs.

## Configuration

- CLKCTL_12H_EN defined: 12-hour mode.
  - hours ranges 1..12. Reset state is 12:00:00, pm = 0.
  - Time advance: 11:59:59 → 12:00:00 toggles pm; 12:59:59 → 01:00:00 does not toggle pm.
  - SET_HR increment: 12 → 1 leaves pm unchanged; 11 → 12 toggles pm.
- CLKCTL_12H_EN undefined: 24-hour mode as described in Operation; pm is tied to 0.

## Test plan

- TICK_DIV=10, release reset, run 35 cycles → sec_tick high in cycles 10, 20, 30 after release; seconds = 3; blink = 0.
- Preload 23:59:58 via set mode, RUN 2 ticks → 23:59:59 then 00:00:00, with sec_tick high on each advance.
- btn_run at prescaler = 4, wait 50 cycles, btn_run again → no ticks during PAUSE; next tick exactly 6 cycles after resume.
- btn_mode, 25×btn_inc, btn_mode, 61×btn_inc, btn_mode → hours = 1, minutes = 1, seconds = 0, mode = RUN, hours unchanged by the minute wrap.
- btn_mode and btn_inc in the same cycle from RUN → mode = SET_HR, hours unchanged. Then rst_n pulse mid-SET_MIN → all outputs at reset values asynchronously.
- With CLKCTL_12H_EN, TICK_DIV=10: from 11:59:59 pm=0, one tick → 12:00:00 pm=1. Set 12:59:59, one tick → 01:00:00 pm=1.
